// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store bus between the datapath and the data-memory responder.
//   req_valid/req_ready   request handshake (master -> slave)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 word
//   req_signed            sign-extend byte/half loads
//   req_addr              byte address
//   req_wdata             store data, right-justified
//   rsp_valid/rsp_ready   response handshake (slave -> master)
//   rsp_rdata             extended load data, 0 for stores
//   rsp_err               misaligned access flag
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory with programmable wait states.
// Accepts one load/store at a time, waits WAIT_CYCLES edges, performs a byte/half/word access on
// 2**ADDR_WIDTH words of little-endian storage and holds the response until it is taken.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset (0 = reset); storage is not cleared
//   bus   data_mem_responder_if.slave (request and response channels)
//   busy  high whenever the FSM is not idle
// Build option: define DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses with rsp_err
// (no write, zero data). Without it, low address bits are ignored to force alignment.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_responder_if.slave bus,
    output logic                busy
);
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned AW       = ADDR_WIDTH + 2;
    localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Request latched at acceptance; bus inputs are ignored afterwards.
    logic          write_q;
    logic [1:0]    size_q;
    logic          sgn_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0] old_word, new_word, lane_mask, lane_data, shifted, load_val;
    logic [1:0]  lane;
    logic [4:0]  shamt;
    logic        is_half, is_word, misalign, access;

    // Address bits above the array are ignored (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:AW];

    assign access = (state_q == StWait) && (cnt_q == 4'd0);

    always_comb begin
        word_idx = addr_q[AW-1:2];
        old_word = mem[word_idx];
        is_word  = size_q[1];
        is_half  = (size_q == 2'b01);
`ifdef DMEM_MISALIGN_ERR_EN
        misalign = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        // Lane of the least-significant byte, with alignment forced for half/word.
        if (is_word) begin
            lane = 2'b00;
        end else if (is_half) begin
            lane = {addr_q[1], 1'b0};
        end else begin
            lane = addr_q[1:0];
        end
        shamt   = {lane, 3'b000};
        shifted = old_word >> shamt;

        if (is_word) begin
            load_val = shifted;
        end else if (is_half) begin
            load_val = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
        end else begin
            load_val = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
        end

        lane_mask = (is_word ? 32'hFFFF_FFFF : (is_half ? 32'h0000_FFFF : 32'h0000_00FF)) << shamt;
        lane_data = wdata_q << shamt;
        new_word  = (old_word & ~lane_mask) | (lane_data & lane_mask);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    state_d = StWait;
                    cnt_d   = WaitLoad;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = (write_q || misalign) ? 32'h0 : load_val;
                    err_d   = misalign;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else if (state_q == StIdle && bus.req_valid) begin
            write_q <= bus.req_write;
            size_q  <= bus.req_size;
            sgn_q   <= bus.req_signed;
            addr_q  <= bus.req_addr[AW-1:0];
            wdata_q <= bus.req_wdata;
        end
    end

    // Storage has no reset; a reset before the access edge drops the store via state_q.
    always_ff @(posedge clk) begin
        if (access && write_q && !misalign) begin
            mem[word_idx] <= new_word;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, hand-written multi-cycle
// sequences (backpressure, reset mid-operation, misalignment) and randomized traffic checked
// against a byte-array reference model.
module tb_data_mem_responder;
    localparam int unsigned AW   = 10;
    localparam int unsigned WAIT = 2;

    logic clk;
    logic rst;
    logic busy;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [$];

    // Reference memory: one byte per byte address inside the 4 KiB array.
    logic [7:0] ref_bytes [4096];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_err = exp_err;
        tbl.push_back(v);
    endtask

    function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int n;
        int base;
        logic [31:0] v;
        n   = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        err = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        err = (int'(a[1:0]) % n) != 0;
`endif
        base = int'(a[11:0]);
        base = base - (base % n);
        rd   = 32'h0;
        if (err) return;
        if (w) begin
            for (int k = 0; k < n; k++) ref_bytes[base + k] = 8'(wd >> (8 * k));
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[base + k]) << (8 * k));
            if (n < 4 && sg && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endfunction

    // One complete transaction; hold = cycles of rsp_ready=0 after rsp_valid rises, during which
    // a competing request is offered and must be refused.
    task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        int guard;
        rd  = 32'h0;
        er  = 1'b0;
        lat = 0;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check("req_ready_wait", {31'h0, bus.req_ready}, 32'h1);
            return;
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.rsp_ready  = (hold == 0);
        @(posedge clk);
        #1;
        // Request fields change after acceptance and must not matter.
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.rsp_valid) begin
            check("rsp_timeout", {31'h0, bus.rsp_valid}, 32'h1);
            bus.rsp_ready = 1'b1;
            return;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
            check("bp_rsp_rdata", bus.rsp_rdata, rd);
            check("bp_busy", {31'h0, busy}, 32'h1);
            check("bp_req_ready", {31'h0, bus.req_ready}, 32'h0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_rsp", {29'h0, busy, bus.rsp_valid, bus.req_ready}, 32'h1);
    endtask

    task automatic rand_op(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat;
        model(w, sz, sg, a, wd, exp_rd, exp_er);
        xact(w, sz, sg, a, wd, hold, rd, er, lat);
        check("rand_rdata", rd, exp_rd);
        check("rand_err", {31'h0, er}, {31'h0, exp_er});
        check("rand_latency", lat, WAIT + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b1;
        rst            = 1'b0;

        // Reset, then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);

        // Directed table: sizes 00 byte, 01 half, 10/11 word.
        add_vec(1, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0);
        add_vec(0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
        add_vec(1, 2'b10, 0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 0);
        add_vec(1, 2'b00, 0, 32'h0000_0022, 32'h0000_00AA, 32'h0000_0000, 0);
        add_vec(0, 2'b10, 0, 32'h0000_0020, 32'h0,         32'h11AA_3344, 0);
        add_vec(0, 2'b00, 1, 32'h0000_0022, 32'h0,         32'hFFFF_FFAA, 0);
        add_vec(0, 2'b00, 0, 32'h0000_0022, 32'h0,         32'h0000_00AA, 0);
        add_vec(0, 2'b01, 1, 32'h0000_0020, 32'h0,         32'h0000_3344, 0);
        add_vec(0, 2'b01, 1, 32'h0000_0022, 32'h0,         32'h0000_11AA, 0);
        add_vec(1, 2'b01, 0, 32'h0000_0022, 32'h7777_BEEF, 32'h0000_0000, 0);
        add_vec(0, 2'b10, 0, 32'h0000_0020, 32'h0,         32'hBEEF_3344, 0);
        add_vec(0, 2'b01, 1, 32'h0000_0022, 32'h0,         32'hFFFF_BEEF, 0);
        add_vec(0, 2'b01, 0, 32'h0000_0022, 32'h0,         32'h0000_BEEF, 0);
        add_vec(1, 2'b00, 0, 32'h0000_0023, 32'h1234_5680, 32'h0000_0000, 0);
        add_vec(0, 2'b00, 1, 32'h0000_0023, 32'h0,         32'hFFFF_FF80, 0);
        add_vec(0, 2'b10, 0, 32'h0000_0020, 32'h0,         32'h80EF_3344, 0);
        add_vec(0, 2'b10, 0, 32'h0000_1010, 32'h0,         32'hDEAD_BEEF, 0);
        add_vec(1, 2'b11, 0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0000, 0);
        add_vec(0, 2'b11, 0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 0);
        add_vec(0, 2'b00, 0, 32'h0000_0041, 32'h0,         32'h0000_00F0, 0);
        add_vec(0, 2'b00, 1, 32'h0000_0041, 32'h0,         32'hFFFF_FFF0, 0);

        foreach (tbl[i]) begin
            xact(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, 0, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].exp_err});
            check($sformatf("vec%0d_latency", i), lat, WAIT + 1);
        end

        // Response backpressure for 5 cycles with a competing request offered.
        xact(0, 2'b10, 0, 32'h0000_0010, 32'h0, 5, rd, er, lat);
        check("bp_load_rdata", rd, 32'hDEAD_BEEF);
        check("bp_load_latency", lat, WAIT + 1);

        // Reset during WAIT drops the pending store.
        xact(1, 2'b10, 0, 32'h0000_0030, 32'h0, 0, rd, er, lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0000_0030;
        bus.req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("midrst_busy_before", {31'h0, busy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check("midrst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        xact(0, 2'b10, 0, 32'h0000_0030, 32'h0, 0, rd, er, lat);
        check("midrst_load", rd, 32'h0);

        // Misaligned accesses.
        xact(1, 2'b10, 0, 32'h0000_0031, 32'h5566_7788, 0, rd, er, lat);
        check("mis_store_rdata", rd, 32'h0);
        check("mis_store_latency", lat, WAIT + 1);
`ifdef DMEM_MISALIGN_ERR_EN
        check("mis_store_err", {31'h0, er}, 32'h1);
        xact(0, 2'b10, 0, 32'h0000_0030, 32'h0, 0, rd, er, lat);
        check("mis_store_effect", rd, 32'h0);
        xact(0, 2'b01, 1, 32'h0000_0021, 32'h0, 0, rd, er, lat);
        check("mis_half_err", {31'h0, er}, 32'h1);
        check("mis_half_rdata", rd, 32'h0);
`else
        check("mis_store_err", {31'h0, er}, 32'h0);
        xact(0, 2'b10, 0, 32'h0000_0030, 32'h0, 0, rd, er, lat);
        check("mis_store_effect", rd, 32'h5566_7788);
        xact(0, 2'b01, 1, 32'h0000_0021, 32'h0, 0, rd, er, lat);
        check("mis_half_err", {31'h0, er}, 32'h0);
        check("mis_half_rdata", rd, 32'h0000_3344);
`endif

        // Randomized traffic on words 64..71 (0x100..0x11F), with aliasing upper address bits.
        for (int i = 0; i < 8; i++) begin
            rand_op(1, 2'b10, 0, 32'h100 + 32'(i * 4), $urandom, 0);
        end
        for (int i = 0; i < 160; i++) begin
            logic [31:0] a;
            int          hold;
            a    = (32'($urandom_range(0, 15)) << 12) | 32'h100
                 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            rand_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, hold);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
